// File: rtl/boot_sequencer.sv
// Boot sequencer: loads a program into instruction memory, then releases the cpu until halt.
// Optional RUN watchdog is enabled by defining SEQ_TIMEOUT_EN.
module boot_sequencer #(
    parameter int              n          = 32,
    parameter int              DEPTH      = 64,
    parameter logic [n-1:0]    HALT_INSTR = 32'hFC00_0000,
    parameter int              MAX_CYCLES = 1000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_load_valid,
    input  logic [n-1:0]  i_load_data,
    input  logic          i_load_last,
    input  logic [n-1:0]  i_instr,
    output logic          o_load_ready,
    output logic          o_imem_we,
    output logic [n-1:0]  o_imem_addr,
    output logic [n-1:0]  o_imem_wdata,
    output logic          o_cpu_reset,
    output logic          o_done,
    output logic          o_error,
    output logic          o_timeout,
    output logic [31:0]   o_cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [n-3:0] IDX_LAST = (n-2)'(DEPTH - 1);
    localparam logic [n-3:0] IDX_ONE  = 1;

    state_t        r_state;
    logic [n-3:0]  r_index;
    logic [31:0]   r_cycle;
    logic          r_done;
    logic          r_error;
    logic          w_accept;
    logic          w_halt;
    logic          w_last_slot;

    assign o_load_ready  = (r_state == S_LOAD);
    assign o_cpu_reset   = (r_state != S_RUN);
    assign w_accept      = i_load_valid & o_load_ready;
    assign w_halt        = (i_instr == HALT_INSTR);
    assign w_last_slot   = (r_index == IDX_LAST);
    assign o_imem_we     = w_accept;
    assign o_imem_addr   = {r_index, 2'b00};
    assign o_imem_wdata  = i_load_data;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign o_cycle_count = r_cycle;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(MAX_CYCLES - 1);
    logic r_timeout;
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_cycle <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_LOAD;
                        r_index <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_index <= r_index + IDX_ONE;
                        if (i_load_last) begin
                            r_state <= S_RUN;
                        end else if (w_last_slot) begin
                            // Memory full without a last word: the program cannot be trusted.
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_cycle <= r_cycle + 32'd1;
                    if (w_halt) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (r_cycle == WD_LAST) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    if (i_start) begin
                        r_state <= S_LOAD;
                        r_index <= '0;
                        r_cycle <= '0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized and directed bench for boot_sequencer against a session-level reference model.
module tb_boot_sequencer;

    localparam int          N     = 32;
    localparam int          DEPTH = 4;
    localparam int          MAXC  = 8;
    localparam logic [31:0] HALT  = 32'hFC00_0000;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, load_valid, load_last;
    logic [31:0] load_data, instr;
    logic        load_ready, imem_we, cpu_reset, done, error, timeout;
    logic [31:0] imem_addr, imem_wdata, cycle_count;

    always #5 clk = ~clk;

    boot_sequencer #(
        .n(N), .DEPTH(DEPTH), .HALT_INSTR(HALT), .MAX_CYCLES(MAXC)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_load_valid(load_valid), .i_load_data(load_data), .i_load_last(load_last),
        .i_instr(instr),
        .o_load_ready(load_ready), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
        .o_imem_wdata(imem_wdata), .o_cpu_reset(cpu_reset), .o_done(done),
        .o_error(error), .o_timeout(timeout), .o_cycle_count(cycle_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: session phase plus counters.
    int          m_ph = 0;   // 0 idle, 1 loading, 2 running, 3 finished
    int          m_idx = 0;
    logic [31:0] m_cnt = 0;
    bit          m_done = 0, m_err = 0, m_to = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_idx = 0; m_cnt = 0; m_done = 0; m_err = 0; m_to = 0;
        end else if (m_ph == 0) begin
            if (start) begin m_ph = 1; m_idx = 0; end
        end else if (m_ph == 1) begin
            if (load_valid) begin
                if (load_last) m_ph = 2;
                else if (m_idx == DEPTH - 1) begin m_err = 1; m_done = 1; m_ph = 3; end
                m_idx = m_idx + 1;
            end
        end else if (m_ph == 2) begin
            if (instr == HALT) begin m_done = 1; m_ph = 3; end
            else if (TO_EN && m_cnt == MAXC - 1) begin m_to = 1; m_done = 1; m_ph = 3; end
            m_cnt = m_cnt + 1;
        end else begin
            if (start) begin
                m_ph = 1; m_idx = 0; m_cnt = 0; m_done = 0; m_err = 0; m_to = 0;
            end
        end
    end

    bit          cmp_en = 0;
    logic [31:0] wlog[$];
    int          lowcnt = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cpu_reset",   {31'd0, cpu_reset},  {31'd0, m_ph != 2});
            chk("load_ready",  {31'd0, load_ready}, {31'd0, m_ph == 1});
            chk("imem_we",     {31'd0, imem_we},    {31'd0, (m_ph == 1) && load_valid});
            if (m_ph == 1) begin
                chk("imem_addr",  imem_addr,  32'(m_idx * 4));
                chk("imem_wdata", imem_wdata, load_data);
            end
            chk("done",        {31'd0, done},    {31'd0, m_done});
            chk("error",       {31'd0, error},   {31'd0, m_err});
            chk("timeout",     {31'd0, timeout}, {31'd0, m_to});
            chk("cycle_count", cycle_count, m_cnt);
            if (imem_we) wlog.push_back(imem_addr);
            if (!cpu_reset) lowcnt++;
        end
    end

    task automatic step(input logic rst, input logic st, input logic lv,
                        input logic [31:0] ld, input logic ll, input logic [31:0] ins);
        reset = rst; start = st; load_valid = lv; load_data = ld; load_last = ll; instr = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 32'h0, 0, 32'h1);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 32'h0, 0, 32'h1);
        step(1, 0, 0, 32'h0, 0, 32'h1);
        wlog.delete();
        lowcnt = 0;
    endtask

    int wsz;
    int exp_cnt;

    initial begin
        reset = 1; start = 0; load_valid = 0; load_data = 0; load_last = 0; instr = 1;
        @(posedge clk);
        #1;
        cmp_en = 1;

        // Reset state
        do_reset();
        chk("rst_cpu_reset",  {31'd0, cpu_reset},  32'd1);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_count",      cycle_count,         32'd0);

        // Basic session
        step(0, 1, 0, 32'h0, 0, 32'h1);
        step(0, 0, 1, 32'h2008_0005, 0, 32'h1);
        step(0, 0, 1, 32'h2109_0003, 0, 32'h1);
        step(0, 0, 1, HALT, 1, 32'h1);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 32'h0, 0, HALT);
        idle(2);
        chk("basic_count",  cycle_count, 32'd4);
        chk("basic_done",   {31'd0, done}, 32'd1);
        chk("basic_nwr",    32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("basic_a0", wlog[0], 32'd0);
            chk("basic_a1", wlog[1], 32'd4);
            chk("basic_a2", wlog[2], 32'd8);
        end
        chk("basic_lowcnt", 32'(lowcnt), 32'd4);

        // Overflow
        do_reset();
        step(0, 1, 0, 32'h0, 0, 32'h1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h100 + 32'(i), 0, HALT);
        idle(2);
        chk("ovf_nwr",    32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) chk("ovf_a3", wlog[3], 32'd12);
        chk("ovf_error",  {31'd0, error}, 32'd1);
        chk("ovf_done",   {31'd0, done},  32'd1);
        chk("ovf_lowcnt", 32'(lowcnt), 32'd0);

        // Start in DONE after overflow clears the flags
        step(0, 1, 0, 32'h0, 0, 32'h1);
        chk("restart_error", {31'd0, error}, 32'd0);
        chk("restart_done",  {31'd0, done},  32'd0);
        chk("restart_ready", {31'd0, load_ready}, 32'd1);

        // Start ignored in LOAD and RUN, load_valid ignored in RUN
        step(0, 1, 1, 32'hAAAA_0001, 0, 32'h1);
        step(0, 1, 1, 32'hAAAA_0002, 1, 32'h1);
        wsz = wlog.size();
        step(0, 1, 1, 32'hBBBB_0000, 0, 32'h0);
        step(0, 1, 1, 32'hBBBB_0001, 1, 32'h0);
        step(0, 0, 0, 32'h0, 0, HALT);
        chk("run_no_writes", 32'(wlog.size()), 32'(wsz));
        chk("run_count3",    cycle_count, 32'd3);
        chk("run_done",      {31'd0, done}, 32'd1);
        idle(1);
        step(0, 1, 0, 32'h0, 0, 32'h1);
        chk("restart2_count", cycle_count, 32'd0);
        chk("restart2_done",  {31'd0, done}, 32'd0);

        // Reset in the 10th RUN cycle
        do_reset();
        step(0, 1, 0, 32'h0, 0, 32'h1);
        step(0, 0, 1, 32'h1234, 1, 32'h1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 32'h0, 0, 32'h1);
        chk("mid_count9", cycle_count, 32'd9);
        step(1, 0, 0, 32'h0, 0, 32'h1);
        chk("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("mid_count",     cycle_count, 32'd0);
        chk("mid_done",      {31'd0, done}, 32'd0);

        // Watchdog, or its absence
        do_reset();
        step(0, 1, 0, 32'h0, 0, 32'h1);
        step(0, 0, 1, 32'h55, 1, 32'h1);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 32'h0, 0, 32'h7);
        exp_cnt = TO_EN ? 8 : 100;
        chk("wd_count",     cycle_count, 32'(exp_cnt));
        chk("wd_timeout",   {31'd0, timeout},   {31'd0, TO_EN});
        chk("wd_done",      {31'd0, done},      {31'd0, TO_EN});
        chk("wd_cpu_reset", {31'd0, cpu_reset}, {31'd0, TO_EN});

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 80) == 0, ($urandom % 6) == 0, $urandom % 2,
                 $urandom, ($urandom % 4) == 0,
                 (($urandom % 10) == 0) ? HALT : $urandom);
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameter n, default 32: data/address width, matching the cpu word width.
REQ-002 Parameter DEPTH, default 64: instruction memory depth in words.
REQ-003 Parameter HALT_INSTR, default 32'hFC00_0000: instruction word that ends a run.
REQ-004 Parameter MAX_CYCLES, default 1000: watchdog limit in RUN cycles, used only with SEQ_TIMEOUT_EN.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a load-then-run session.
REQ-008 load_valid  input  1  load_data is valid this cycle.
REQ-009 load_data  input  n  program word to write.
REQ-010 load_last  input  1  qualifies the final program word.
REQ-011 instr  input  n  instruction currently fetched by the cpu.
REQ-012 load_ready  output  1  sequencer accepts load words.
REQ-013 imem_we  output  1  instruction memory write enable.
REQ-014 imem_addr  output  n  byte address, equal to word index times 4.
REQ-015 imem_wdata  output  n  write data, equal to load_data.
REQ-016 cpu_reset  output  1  drives the cpu reset input.
REQ-017 done  output  1  session finished.
REQ-018 error  output  1  load overflow occurred.
REQ-019 timeout  output  1  watchdog expired.
REQ-020 cycle_count  output  32  RUN cycles in the current or last session.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, RUN and DONE, held in one state register.
REQ-022 cpu_reset SHALL be 1 in every state except RUN, decoded from the state register only.
REQ-023 Transitions:
- IDLE: start -> LOAD.
- DONE: start -> LOAD, clearing the word index, cycle_count, done, error and timeout on that edge.
- start SHALL be ignored in LOAD and RUN.
REQ-024 load_ready SHALL equal 1 exactly when the state is LOAD.
REQ-025 imem_we SHALL equal load_valid AND load_ready combinationally, with imem_addr = {index, 2'b00} and imem_wdata = load_data in the same cycle.
REQ-026 load_valid and load_data SHALL have no effect outside LOAD.
REQ-027 Each accepted word SHALL increment the word index by 1.
REQ-028 An accepted word with load_last = 1 SHALL cause LOAD -> RUN.
REQ-029 An accepted word at index DEPTH-1 with load_last = 0 SHALL still be written, then set error = 1 and cause LOAD -> DONE without entering RUN.
REQ-030 In RUN, cycle_count SHALL increment by 1 every cycle, including the cycle in which the halt is seen; it wraps modulo 2^32.
REQ-031 In RUN, instr == HALT_INSTR SHALL cause RUN -> DONE on that edge; done = 1 from the next cycle onward.
REQ-032 cycle_count SHALL hold its value in LOAD, DONE and IDLE.
REQ-033 If halt and watchdog expiry occur in the same cycle, halt SHALL win and timeout SHALL remain 0.

Reset
REQ-034 reset SHALL, from any state (including mid-LOAD or mid-RUN), force on the next edge:
- state = IDLE;
- word index = 0, cycle_count = 0;
- done = 0, error = 0, timeout = 0.
REQ-035 During and after reset, outputs SHALL be: cpu_reset = 1, load_ready = 0, imem_we = 0.
REQ-036 reset SHALL take priority over start and over every other input.

Configuration
REQ-037 Macro SEQ_TIMEOUT_EN, when defined, SHALL add a RUN watchdog.
- Trigger: cycle_count == MAX_CYCLES-1 in RUN without a halt.
- Response: RUN -> DONE with timeout = 1 and done = 1 from the next cycle.
REQ-038 Without SEQ_TIMEOUT_EN:
- timeout SHALL be tied to 0;
- RUN SHALL end only on halt or reset;
- MAX_CYCLES SHALL be unused.

Verification
REQ-039 Basic session: reset, start, 3 words (0x20080005, 0x21090003, HALT_INSTR; last on word 3), then HALT_INSTR fetched on the 4th RUN cycle -> imem writes at addresses 0, 4, 8; cpu_reset low for exactly 4 cycles; cycle_count = 4; done = 1.
REQ-040 Overflow: DEPTH = 4, 4 words with load_last = 0 -> 4 writes (addresses 0 to 12), error = 1, done = 1, cpu_reset never deasserts.
REQ-041 Reset mid-RUN: reset asserted at RUN cycle 10 -> next cycle state IDLE, cpu_reset = 1, cycle_count = 0, done = 0.
REQ-042 Watchdog (SEQ_TIMEOUT_EN, MAX_CYCLES = 8), no halt -> cycle_count = 8, timeout = 1, done = 1; same run without the macro -> still in RUN after 100 cycles, timeout = 0.
REQ-043 Restart and ignored inputs: start during LOAD and RUN is ignored, and load_valid in RUN produces no imem_we; start in DONE -> LOAD with cycle_count, done and error cleared.
